// File: rtl/booth_r4_mul_pkg.sv
// Shared types for the radix-4 Booth multiplier:
// FSM states, recoded digits and the group-to-digit map.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_e;

  function automatic digit_e booth_digit(input logic [2:0] grp);
    unique case (grp)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_mul_if.sv
// Start/busy/valid handshake bundle for the Booth multiplier:
// operands in, product and status out.
interface booth_r4_mul_if #(
  parameter int WIDTH = 16
) ();

  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   X;
  logic [WIDTH-1:0]   Y;
  logic               busy;
  logic [2*WIDTH-1:0] Z;
  logic               valid;

  modport master (
    output start,
    output is_signed,
    output X,
    output Y,
    input  busy,
    input  Z,
    input  valid
  );

  modport slave (
    input  start,
    input  is_signed,
    input  X,
    input  Y,
    output busy,
    output Z,
    output valid
  );

endinterface

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: one 3-bit multiplier group
// to zero / negate / double control flags.
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0] grp_i,
  output logic       zero_o,
  output logic       neg_o,
  output logic       two_o
);

  digit_e dig;

  always_comb begin
    dig    = booth_digit(grp_i);
    zero_o = 1'b0;
    neg_o  = 1'b0;
    two_o  = 1'b0;
    unique case (dig)
      ZERO: zero_o = 1'b1;
      POS2: two_o  = 1'b1;
      NEG1: neg_o  = 1'b1;
      NEG2: begin
        neg_o = 1'b1;
        two_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier, signed or unsigned
// per operation, two multiplier bits retired per cycle.
module booth_r4_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  booth_r4_mul_if.slave bus
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int E  = WIDTH + 2;
  localparam int CW = $clog2(N + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_r4_mul: WIDTH must be even and >= 4");
  end

  state_e          state_q;
  logic [E-1:0]    m_q;
  logic [E:0]      a_q;
  logic [E-1:0]    q_q;
  logic            q1_q;
  logic [CW-1:0]   cnt_q;
  logic [2*WIDTH-1:0] z_q;
  logic            valid_q;

  logic            dg_zero;
  logic            dg_neg;
  logic            dg_two;
  logic [E:0]      addend;
  logic [E:0]      a_d;
  logic [E-1:0]    x_ext;
  logic [E-1:0]    y_ext;
  logic [2*WIDTH-1:0] z_d;
  logic            last;

  booth_r4_enc u_enc (
    .grp_i  ({q_q[1:0], q1_q}),
    .zero_o (dg_zero),
    .neg_o  (dg_neg),
    .two_o  (dg_two)
  );

  // Extension to E bits lets the signed datapath serve unsigned operands too.
  always_comb begin
    x_ext = bus.is_signed ? {{2{bus.X[WIDTH-1]}}, bus.X}
                          : {2'b00, bus.X};
    y_ext = bus.is_signed ? {{2{bus.Y[WIDTH-1]}}, bus.Y}
                          : {2'b00, bus.Y};
    addend = '0;
    if (!dg_zero) begin
      addend = dg_two ? {m_q, 1'b0} : {m_q[E-1], m_q};
    end
    a_d  = dg_neg ? a_q - addend : a_q + addend;
    z_d  = {a_q[WIDTH-3:0], q_q};
    last = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            z_q     <= z_d;
            valid_q <= 1'b1;
          end
          if (bus.start) begin
            m_q     <= y_ext;
            q_q     <= x_ext;
            a_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          a_q   <= {{2{a_d[E]}}, a_d[E:2]};
          q_q   <= {a_d[1:0], q_q[E-1:2]};
          q1_q  <= q_q[1];
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state_q == CALC);
  assign bus.Z     = z_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_booth_r4_mul.sv
// Bench for booth_r4_mul at WIDTH=8 and WIDTH=16: directed table,
// handshake corner sequences and random ops against an arithmetic model.
module tb_booth_r4_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  booth_r4_mul_if #(.WIDTH(8))  b8 ();
  booth_r4_mul_if #(.WIDTH(16)) b16 ();

  booth_r4_mul #(.WIDTH(8)) u8 (
    .clk   (clk),
    .reset (rst),
    .bus   (b8)
  );

  booth_r4_mul #(.WIDTH(16)) u16 (
    .clk   (clk),
    .reset (rst),
    .bus   (b16)
  );

  typedef struct {
    bit          s;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] z;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Plain integer product of the operands as interpreted by the mode.
  function automatic logic [63:0] ref_mul(input int w, input bit s,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    longint a;
    longint b;
    logic [63:0] p;
    a = longint'(x);
    b = longint'(y);
    if (s && x[w-1]) a = a - (longint'(1) << w);
    if (s && y[w-1]) b = b - (longint'(1) << w);
    p = 64'(a * b);
    return p & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic [31:0] pick(input int w, input int k);
    logic [31:0] m;
    m = 32'((64'd1 << w) - 64'd1);
    case (k)
      0: return 32'd0;
      1: return m;
      2: return 32'd1 << (w - 1);
      3: return (32'd1 << (w - 1)) - 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  task automatic launch8(input bit s, input logic [7:0] x,
                         input logic [7:0] y);
    b8.is_signed = s;
    b8.X = x;
    b8.Y = y;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
  endtask

  task automatic wait8(input int c0, output int cyc);
    cyc = c0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!b8.valid && cyc < 40);
  endtask

  task automatic launch16(input bit s, input logic [15:0] x,
                          input logic [15:0] y);
    b16.is_signed = s;
    b16.X = x;
    b16.Y = y;
    b16.start = 1'b1;
    @(posedge clk); #1;
    b16.start = 1'b0;
  endtask

  task automatic wait16(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!b16.valid && cyc < 40);
  endtask

  task automatic count_valid8(input int ncyc, output int nv);
    nv = 0;
    repeat (ncyc) begin
      @(posedge clk); #1;
      if (b8.valid) nv++;
    end
  endtask

  initial begin
    int cyc;
    int nv;
    logic [31:0] x;
    logic [31:0] y;

    tbl[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    tbl[1] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    tbl[2] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    tbl[3] = '{1'b0, 8'h80, 8'h02, 16'h0100};
    tbl[4] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    tbl[5] = '{1'b0, 8'h00, 8'hFF, 16'h0000};
    tbl[6] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    tbl[7] = '{1'b0, 8'h7F, 8'h80, 16'h3F80};
    tbl[8] = '{1'b1, 8'h80, 8'h01, 16'hFF80};
    tbl[9] = '{1'b1, 8'h80, 8'h7F, 16'hC080};

    b8.start = 1'b0;  b8.is_signed = 1'b0;  b8.X = '0;  b8.Y = '0;
    b16.start = 1'b0; b16.is_signed = 1'b0; b16.X = '0; b16.Y = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_z", 64'(b8.Z), 64'd0);
    chk("reset_valid", 64'(b8.valid), 64'd0);
    chk("reset_busy", 64'(b8.busy), 64'd0);
    chk("reset_z16", 64'(b16.Z), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      launch8(tbl[i].s, tbl[i].x, tbl[i].y);
      chk($sformatf("tbl%0d_busy_calc", i), 64'(b8.busy), 64'd1);
      wait8(0, cyc);
      chk($sformatf("tbl%0d_lat", i), 64'(cyc), 64'd6);
      chk($sformatf("tbl%0d_z", i), 64'(b8.Z), 64'(tbl[i].z));
      chk($sformatf("tbl%0d_busy_valid", i), 64'(b8.busy), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_pulse", i), 64'(b8.valid), 64'd0);
      chk($sformatf("tbl%0d_hold", i), 64'(b8.Z), 64'(tbl[i].z));
    end

    // Start while busy must be dropped.
    launch8(1'b1, 8'd5, 8'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    b8.X = 8'd3;
    b8.Y = 8'd3;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    wait8(3, cyc);
    chk("busy_start_lat", 64'(cyc), 64'd6);
    chk("busy_start_z", 64'(b8.Z), 64'd35);
    count_valid8(12, nv);
    chk("busy_start_no_second", 64'(nv), 64'd0);

    // Back-to-back: start held in DONE.
    launch8(1'b0, 8'd10, 8'd20);
    repeat (5) begin
      @(posedge clk); #1;
    end
    b8.X = 8'd30;
    b8.Y = 8'd40;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    chk("b2b_first_valid", 64'(b8.valid), 64'd1);
    chk("b2b_first_z", 64'(b8.Z), 64'd200);
    wait8(0, cyc);
    chk("b2b_spacing", 64'(cyc), 64'd6);
    chk("b2b_second_z", 64'(b8.Z), 64'd1200);

    // Reset in the middle of CALC.
    launch8(1'b1, 8'hFD, 8'd9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_calc_z", 64'(b8.Z), 64'd0);
    chk("rst_calc_valid", 64'(b8.valid), 64'd0);
    chk("rst_calc_busy", 64'(b8.busy), 64'd0);
    count_valid8(12, nv);
    chk("rst_calc_no_valid", 64'(nv), 64'd0);
    launch8(1'b1, 8'hFD, 8'd9);
    wait8(0, cyc);
    chk("rst_after_z", 64'(b8.Z), 64'hFFE5);

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        if (i < 25) begin
          x = pick(8, i % 5);
          y = pick(8, i / 5);
        end else begin
          x = $urandom & 32'hFF;
          y = $urandom & 32'hFF;
        end
        launch8(m[0], x[7:0], y[7:0]);
        wait8(0, cyc);
        chk($sformatf("r8 s%0d lat", m), 64'(cyc), 64'd6);
        chk($sformatf("r8 s%0d %0h*%0h", m, x[7:0], y[7:0]),
            64'(b8.Z), ref_mul(8, m[0], x, y));
      end
    end

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        if (i < 25) begin
          x = pick(16, i % 5);
          y = pick(16, i / 5);
        end else begin
          x = $urandom & 32'hFFFF;
          y = $urandom & 32'hFFFF;
        end
        launch16(m[0], x[15:0], y[15:0]);
        wait16(cyc);
        chk($sformatf("r16 s%0d lat", m), 64'(cyc), 64'd10);
        chk($sformatf("r16 s%0d %0h*%0h", m, x[15:0], y[15:0]),
            64'(b16.Z), ref_mul(16, m[0], x, y));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
